// File: rtl/i2s_master_tx.sv
// Philips I2S clock-master transmitter: divides clk into sclk/ws and serializes
// one stereo pair per frame, fed from a single-entry holding register.
module i2s_master_tx #(
    parameter int WIDTH   = 16,
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] left_in,
    input  logic [WIDTH-1:0] right_in,
    output logic             sclk_out,
    output logic             ws_out,
    output logic             sdata_out,
    output logic             underrun
);
    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int SLOTS  = 2 * WIDTH;
    localparam int SLOT_W = $clog2(SLOTS);
    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SLOTS - 1);
    localparam logic [SLOT_W-1:0] SLOT_RIGHT = SLOT_W'(WIDTH);

    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic              sclk_q, sclk_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic              ws_q, ws_d;
    logic              sdata_q, sdata_d;
    logic              underrun_q, underrun_d;
    logic              full_q, full_d;
    logic [WIDTH-1:0]  hold_l_q, hold_l_d;
    logic [WIDTH-1:0]  hold_r_q, hold_r_d;
    logic [SLOTS-1:0]  shift_q, shift_d;
    logic              carry_q, carry_d;

    logic tick, fall, load, accept;

    assign tick   = (div_cnt_q == DIV_LAST);
    assign fall   = tick & sclk_q;
    assign load   = fall & (slot_q == SLOT_LAST);
    assign accept = s_valid & ~full_q;

    always_comb begin
        div_cnt_d  = tick ? '0 : div_cnt_q + DIV_W'(1);
        sclk_d     = tick ? ~sclk_q : sclk_q;
        slot_d     = slot_q;
        ws_d       = ws_q;
        sdata_d    = sdata_q;
        underrun_d = 1'b0;
        full_d     = full_q;
        hold_l_d   = hold_l_q;
        hold_r_d   = hold_r_q;
        shift_d    = shift_q;
        carry_d    = carry_q;

        if (fall) begin
            slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_W'(1);
            ws_d   = (slot_d >= SLOT_RIGHT);
            if (load) begin
                // slot 0 still belongs to the previous frame's right LSB
                sdata_d = carry_q;
                carry_d = full_q & hold_r_q[0];
                if (full_q) begin
                    shift_d = {hold_l_q, hold_r_q};
                    full_d  = 1'b0;
                end else begin
                    shift_d    = '0;
                    underrun_d = 1'b1;
                end
            end else begin
                sdata_d = shift_q[SLOTS-1];
                shift_d = {shift_q[SLOTS-2:0], 1'b0};
            end
        end

        // accept only happens when empty, so it never races a load that reads the hold regs
        if (accept) begin
            full_d   = 1'b1;
            hold_l_d = left_in;
            hold_r_d = right_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q  <= '0;
            sclk_q     <= 1'b0;
            slot_q     <= SLOT_LAST;
            ws_q       <= 1'b0;
            sdata_q    <= 1'b0;
            underrun_q <= 1'b0;
            full_q     <= 1'b0;
            hold_l_q   <= '0;
            hold_r_q   <= '0;
            shift_q    <= '0;
            carry_q    <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            sclk_q     <= sclk_d;
            slot_q     <= slot_d;
            ws_q       <= ws_d;
            sdata_q    <= sdata_d;
            underrun_q <= underrun_d;
            full_q     <= full_d;
            hold_l_q   <= hold_l_d;
            hold_r_q   <= hold_r_d;
            shift_q    <= shift_d;
            carry_q    <= carry_d;
        end
    end

    assign s_ready   = ~full_q;
    assign sclk_out  = sclk_q;
    assign ws_out    = ws_q;
    assign sdata_out = sdata_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_i2s_master_tx.sv
// Bench for i2s_master_tx: per-cycle frame-level reference model, a table of
// single-frame vectors, and hand sequences for reset, underrun and handshake corners.
module tb_i2s_master_tx;
    localparam int W  = 16;
    localparam int CD = 2;
    localparam int FR = 4 * W * CD;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] left_in;
    logic [W-1:0] right_in;
    logic         sclk_out;
    logic         ws_out;
    logic         sdata_out;
    logic         underrun;

    i2s_master_tx #(.WIDTH(W), .CLK_DIV(CD)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .left_in   (left_in),
        .right_in  (right_in),
        .sclk_out  (sclk_out),
        .ws_out    (ws_out),
        .sdata_out (sdata_out),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state: edges since reset release, holding register, frame contents
    int           n;
    bit           m_full;
    logic [W-1:0] m_l, m_r;
    logic [W-1:0] fr_l [0:1023];
    logic [W-1:0] fr_r [0:1023];
    logic [2*W-1:0] rx    [0:1023];
    logic [2*W-1:0] rx_ws [0:1023];
    bit  last_acc, last_load, prev_sclk;
    int  under_cnt, sdata_ones, total_steps;
    int  under_at[$];

    typedef struct {
        logic [W-1:0] l;
        logic [W-1:0] r;
        logic [30:0]  bits;
        logic         lsb;
    } vec_t;
    vec_t tv [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (step %0d)", name, act, exp, total_steps);
        end
    endtask

    task automatic step();
        bit           acc, ld, e_under, e_sclk, e_ws, e_sd;
        logic [W-1:0] in_l, in_r;
        int           mm, sl, ff;
        acc  = !rst && s_valid && !m_full;
        in_l = left_in;
        in_r = right_in;
        @(posedge clk);
        #1;
        total_steps++;
        ld = 0; e_under = 0; e_sclk = 0; e_ws = 0; e_sd = 0;
        if (rst) begin
            n      = 0;
            m_full = 0;
            acc    = 0;
        end else begin
            n++;
            mm = n / (2 * CD);
            if ((n % (2 * CD)) == 0 && mm >= 1 && ((mm - 1) % (2 * W)) == 0) begin
                ld = 1;
                ff = (mm - 1) / (2 * W);
                if (m_full) begin
                    fr_l[ff] = m_l;
                    fr_r[ff] = m_r;
                    m_full   = 0;
                end else begin
                    fr_l[ff] = '0;
                    fr_r[ff] = '0;
                    e_under  = 1;
                end
            end
            if (acc) begin
                m_full = 1;
                m_l    = in_l;
                m_r    = in_r;
            end
            e_sclk = ((n / CD) % 2) == 1;
            if (mm >= 1) begin
                sl   = (mm - 1) % (2 * W);
                ff   = (mm - 1) / (2 * W);
                e_ws = (sl >= W);
                if (sl == 0)      e_sd = (ff == 0) ? 1'b0 : fr_r[ff-1][0];
                else if (sl <= W) e_sd = fr_l[ff][W-sl];
                else              e_sd = fr_r[ff][2*W-sl];
                if (sclk_out && !prev_sclk) begin
                    rx[ff][sl]    = sdata_out;
                    rx_ws[ff][sl] = ws_out;
                end
            end
        end
        last_acc  = acc;
        last_load = ld;
        chk("sclk_out", {31'd0, sclk_out}, {31'd0, e_sclk});
        chk("ws_out", {31'd0, ws_out}, {31'd0, e_ws});
        chk("sdata_out", {31'd0, sdata_out}, {31'd0, e_sd});
        chk("underrun", {31'd0, underrun}, {31'd0, e_under});
        chk("s_ready", {31'd0, s_ready}, {31'd0, !m_full});
        if (underrun) begin
            under_cnt++;
            under_at.push_back(total_steps);
        end
        if (sdata_out) sdata_ones++;
        prev_sclk = sclk_out;
    endtask

    task automatic do_reset(input int cycles);
        rst      = 1'b1;
        s_valid  = 1'b0;
        left_in  = '0;
        right_in = '0;
        repeat (cycles) step();
        rst        = 1'b0;
        under_cnt  = 0;
        sdata_ones = 0;
        under_at.delete();
    endtask

    function automatic logic [W-1:0] rx_left(input int f);
        logic [W-1:0] v = '0;
        for (int s = 1; s <= W; s++) v = {v[W-2:0], rx[f][s]};
        return v;
    endfunction

    function automatic logic [W-1:0] rx_right(input int f);
        logic [W-1:0] v = '0;
        for (int s = W + 1; s < 2 * W; s++) v = {v[W-2:0], rx[f][s]};
        return {v[W-2:0], rx[f+1][0]};
    endfunction

    initial begin
        int           base, rise_at, fall_at, acc_cnt;
        bit           got;
        logic [30:0]  gb;

        tv[0] = '{16'hA5C3, 16'h0F0F, 31'b1010010111000011000011110000111, 1'b1};
        tv[1] = '{16'h8001, 16'h7FFE, 31'b1000000000000001011111111111111, 1'b0};
        tv[2] = '{16'hFFFF, 16'hFFFF, 31'h7FFFFFFF, 1'b1};
        tv[3] = '{16'h0000, 16'h0001, 31'h00000000, 1'b1};

        n = 0; m_full = 0; total_steps = 0; prev_sclk = 0;

        // reset timing and continuous underrun
        do_reset(3);
        base    = total_steps;
        rise_at = -1;
        fall_at = -1;
        for (int i = 1; i <= 3 * FR + 4; i++) begin
            step();
            if (rise_at < 0 && sclk_out) rise_at = i;
            if (rise_at >= 0 && fall_at < 0 && !sclk_out) fall_at = i;
        end
        chk("first_rise", rise_at, 2);
        chk("first_fall", fall_at, 4);
        chk("underrun_count", under_cnt, 4);
        chk("underrun_sdata_zero", sdata_ones, 0);
        if (under_at.size() >= 4) begin
            chk("underrun_first", under_at[0] - base, 4);
            chk("underrun_spacing", under_at[3] - under_at[0], 3 * FR);
        end

        // table-driven single frames, one vector per frame
        do_reset(3);
        for (int i = 0; i < 4; i++) begin
            s_valid  = 1'b1;
            left_in  = tv[i].l;
            right_in = tv[i].r;
            got = 0;
            for (int c = 0; c < 2 * FR && !got; c++) begin
                step();
                if (last_acc) got = 1;
            end
            chk($sformatf("accept_wait_%0d", i), {31'd0, got}, 1);
        end
        s_valid = 1'b0;
        for (int c = 0; c < 6 * FR && n < 4 * FR + 8; c++) step();
        for (int i = 0; i < 4; i++) begin
            gb = '0;
            for (int s = 1; s < 2 * W; s++) gb = {gb[29:0], rx[i][s]};
            chk($sformatf("frame_bits_%0d", i), {1'b0, gb}, {1'b0, tv[i].bits});
            chk($sformatf("next_slot0_%0d", i), {31'd0, rx[i+1][0]}, {31'd0, tv[i].lsb});
            chk($sformatf("ws_pattern_%0d", i), rx_ws[i], 32'hFFFF0000);
        end

        // accept landing in the frame-start cycle
        do_reset(3);
        repeat (3) step();
        s_valid  = 1'b1;
        left_in  = 16'h1234;
        right_in = 16'h5678;
        step();
        chk("same_cycle_underrun", {31'd0, underrun}, 1);
        chk("same_cycle_accept", {31'd0, last_acc}, 1);
        s_valid = 1'b0;
        for (int c = 0; c < 4 * FR && n < 2 * FR + 8; c++) step();
        chk("same_cycle_frame0_left", {16'd0, rx_left(0)}, 32'h0);
        chk("same_cycle_frame1_left", {16'd0, rx_left(1)}, 32'h1234);
        chk("same_cycle_frame1_right", {16'd0, rx_right(1)}, 32'h5678);

        // reset in the middle of a frame with a pair held
        do_reset(3);
        s_valid  = 1'b1;
        left_in  = 16'hAAAA;
        right_in = 16'h5555;
        got = 0;
        for (int c = 0; c < 2 * FR && !got; c++) begin step(); if (last_acc) got = 1; end
        left_in  = 16'h3C3C;
        right_in = 16'hC3C3;
        got = 0;
        for (int c = 0; c < 2 * FR && !got; c++) begin step(); if (last_acc) got = 1; end
        chk("midreset_second_accept", {31'd0, got}, 1);
        s_valid = 1'b0;
        for (int c = 0; c < FR && n < 11 * 2 * CD; c++) step();
        rst = 1'b1;
        step();
        chk("midreset_ready", {31'd0, s_ready}, 1);
        chk("midreset_sclk", {31'd0, sclk_out}, 0);
        chk("midreset_sdata", {31'd0, sdata_out}, 0);
        rst        = 1'b0;
        under_cnt  = 0;
        sdata_ones = 0;
        repeat (FR) step();
        chk("midreset_underrun", under_cnt, 1);
        chk("midreset_zero_data", sdata_ones, 0);

        // streaming with an incrementing pair
        do_reset(3);
        s_valid  = 1'b1;
        left_in  = 16'h0001;
        right_in = 16'h8001;
        acc_cnt  = 0;
        for (int c = 0; c < 6 * FR; c++) begin
            step();
            if (last_load) chk("ready_after_load", {31'd0, s_ready}, 1);
            if (last_acc) begin
                acc_cnt++;
                left_in  = left_in + 16'd1;
                right_in = right_in + 16'd1;
            end
        end
        s_valid = 1'b0;
        chk("stream_accepts", acc_cnt, 7);
        chk("stream_underruns", under_cnt, 0);
        for (int f = 0; f < 5; f++) begin
            chk($sformatf("stream_left_%0d", f), {16'd0, rx_left(f)}, 32'h0001 + f);
            chk($sformatf("stream_right_%0d", f), {16'd0, rx_right(f)}, 32'h8001 + f);
        end

        // random sparse traffic against the model
        do_reset(2);
        for (int c = 0; c < 10 * FR; c++) begin
            s_valid  = ($urandom_range(0, 49) == 0);
            left_in  = W'($urandom);
            right_in = W'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
